// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode constants and FSM state encoding for the ALU/UART sequencer
package alu_pkg;
   localparam int N_BITS_DEF    = 8;
   localparam int N_BITS_OP_DEF = 6;
   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_NOR = 6'h27;
   typedef enum logic [2:0] {
      S_WAIT_D1, S_WAIT_D2, S_WAIT_OP, S_COMPUTE, S_SEND, S_WAIT_TX
   } state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational N_BITS ALU; a_i/b_i operands, op_i opcode, res_o truncated result (unknown opcode -> 0)
module alu
   import alu_pkg::*;
#(
   parameter int N_BITS    = N_BITS_DEF,
   parameter int N_BITS_OP = N_BITS_OP_DEF
) (
   input  logic [N_BITS-1:0]    a_i,
   input  logic [N_BITS-1:0]    b_i,
   input  logic [N_BITS_OP-1:0] op_i,
   output logic [N_BITS-1:0]    res_o
);
   always_comb begin
      case (op_i)
         N_BITS_OP'(OP_ADD): res_o = a_i + b_i;
         N_BITS_OP'(OP_SUB): res_o = a_i - b_i;
         N_BITS_OP'(OP_AND): res_o = a_i & b_i;
         N_BITS_OP'(OP_OR):  res_o = a_i | b_i;
         N_BITS_OP'(OP_XOR): res_o = a_i ^ b_i;
         N_BITS_OP'(OP_SRA): res_o = $signed(a_i) >>> b_i;
         N_BITS_OP'(OP_SRL): res_o = a_i >> b_i;
         N_BITS_OP'(OP_NOR): res_o = ~(a_i | b_i);
         default:            res_o = '0;
      endcase
   end
endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects data1/data2/opcode bytes from UART RX, computes via alu, sends result to UART TX.
// Ports: i_clk/i_reset (sync, active-high); i_rx_data/i_rx_done RX byte strobe; i_tx_done TX completion;
// o_tx_data/o_tx_start TX request; o_busy while computing/sending; o_error one-clock inter-byte timeout pulse.
module alu_uart_sequencer
   import alu_pkg::*;
#(
   parameter int N_BITS         = N_BITS_DEF,
   parameter int N_BITS_OP      = N_BITS_OP_DEF,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [N_BITS-1:0] i_rx_data,
   input  logic              i_rx_done,
   input  logic              i_tx_done,
   output logic [N_BITS-1:0] o_tx_data,
   output logic              o_tx_start,
   output logic              o_busy,
   output logic              o_error
);
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   state_t                state_q, state_d;
   logic [N_BITS-1:0]     d1_q, d1_d, d2_q, d2_d, res_q, res_d, alu_res;
   logic [N_BITS_OP-1:0]  op_q, op_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  waiting, expired, err_d;
   logic [N_BITS-1:0]     tx_data_q;
   logic                  tx_start_q, busy_q, err_q;
   alu #(.N_BITS(N_BITS), .N_BITS_OP(N_BITS_OP)) u_alu (
      .a_i(d1_q), .b_i(d2_q), .op_i(op_q), .res_o(alu_res)
   );
   always_comb begin
      state_d = state_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      op_d    = op_q;
      res_d   = res_q;
      err_d   = 1'b0;
      waiting = state_q == S_WAIT_D2 || state_q == S_WAIT_OP;
      // a byte arriving on the expiry cycle wins over the timeout
      expired = waiting && !i_rx_done && cnt_q == CW'(TIMEOUT_CYCLES - 1);
      case (state_q)
         S_WAIT_D1: if (i_rx_done) begin d1_d = i_rx_data; state_d = S_WAIT_D2; end
         S_WAIT_D2: if (i_rx_done) begin d2_d = i_rx_data; state_d = S_WAIT_OP; end
         S_WAIT_OP: if (i_rx_done) begin op_d = i_rx_data[N_BITS_OP-1:0]; state_d = S_COMPUTE; end
         S_COMPUTE: begin res_d = alu_res; state_d = S_SEND; end
         S_SEND:    state_d = S_WAIT_TX;
         S_WAIT_TX: if (i_tx_done) state_d = S_WAIT_D1;
         default:   state_d = S_WAIT_D1;
      endcase
      if (expired) begin
         state_d = S_WAIT_D1;
         err_d   = 1'b1;
      end
      // any accepted byte changes state, so counting only while still waiting covers both clear rules
      cnt_d = (waiting && !i_rx_done && !expired) ? cnt_q + 1'b1 : '0;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= S_WAIT_D1;
         d1_q       <= '0;
         d2_q       <= '0;
         op_q       <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         d1_q       <= d1_d;
         d2_q       <= d2_d;
         op_q       <= op_d;
         res_q      <= res_d;
         cnt_q      <= cnt_d;
         // the registered request is issued from SEND, landing two clocks after the opcode edge
         tx_start_q <= state_q == S_SEND;
         if (state_q == S_SEND) tx_data_q <= res_q;
         busy_q     <= state_d == S_COMPUTE || state_d == S_SEND || state_d == S_WAIT_TX;
         err_q      <= err_d;
      end
   end
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_busy     = busy_q;
   assign o_error    = err_q;
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: table-driven, hand-written and randomized checks of alu_uart_sequencer
module tb_alu_uart_sequencer;
   logic       i_clk = 1'b0, i_reset = 1'b1, i_rx_done = 1'b0, i_tx_done = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic [7:0] o_tx_data;
   logic       o_tx_start, o_busy, o_error;
   int         nvec = 0, nerr = 0, e;
   typedef struct {logic [7:0] a, b, op, exp;} vec_t;
   vec_t       tbl [8];
   logic [5:0] ops [8];
   logic [7:0] ra, rb, rop;

   alu_uart_sequencer #(.N_BITS(8), .N_BITS_OP(6), .TIMEOUT_CYCLES(16)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
      .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
      .o_busy(o_busy), .o_error(o_error)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
      int sa = $signed(a);
      int sb = $signed(b);
      int ua = a;
      int ub = b;
      int r;
      case (opb[5:0])
         6'h20:   r = sa + sb;
         6'h22:   r = sa - sb;
         6'h24:   r = ua & ub;
         6'h25:   r = ua | ub;
         6'h26:   r = ua ^ ub;
         6'h27:   r = ~(ua | ub);
         6'h03:   r = (ub > 7) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
         6'h02:   r = (ub > 7) ? 0 : ua / (1 << ub);
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
      i_rx_data = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         i_tx_done = 1'($urandom_range(0, 1));
         tick();
      end
      i_tx_done = 1'b0;
   endtask

   task automatic finish_frame(input logic [7:0] exp, input bit junk);
      tick();
      check("busy_compute", {7'd0, o_busy}, 8'd1);
      check("start_early", {7'd0, o_tx_start}, 8'd0);
      tick();
      check("tx_start", {7'd0, o_tx_start}, 8'd1);
      check("tx_data", o_tx_data, exp);
      tick();
      check("start_pulse", {7'd0, o_tx_start}, 8'd0);
      if (junk) begin
         send_byte(8'hAA);
         check("junk_no_start", {7'd0, o_tx_start}, 8'd0);
      end
      check("tx_hold", o_tx_data, exp);
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      check("busy_clear", {7'd0, o_busy}, 8'd0);
      check("no_error", {7'd0, o_error}, 8'd0);
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] exp, input int gap, input bit junk);
      send_byte(a);
      idle(gap);
      send_byte(b);
      idle(gap);
      send_byte(op);
      finish_frame(exp, junk);
   endtask

   initial begin
      tbl[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
      tbl[1] = '{8'h03, 8'h05, 8'h22, 8'hFE};
      tbl[2] = '{8'h40, 8'h02, 8'h02, 8'h10};
      tbl[3] = '{8'h0F, 8'h01, 8'h3F, 8'h00};
      tbl[4] = '{8'h80, 8'h01, 8'h03, 8'hC0};
      tbl[5] = '{8'hF0, 8'h0F, 8'h27, 8'h00};
      tbl[6] = '{8'h3C, 8'h0F, 8'h26, 8'h33};
      tbl[7] = '{8'h50, 8'h0A, 8'h25, 8'h5A};
      ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
      // reset wins over simultaneous strobes
      i_rx_done = 1'b1;
      i_rx_data = 8'h55;
      i_tx_done = 1'b1;
      tick();
      tick();
      check("rst_tx_data", o_tx_data, 8'h00);
      check("rst_tx_start", {7'd0, o_tx_start}, 8'd0);
      check("rst_busy", {7'd0, o_busy}, 8'd0);
      check("rst_error", {7'd0, o_error}, 8'd0);
      i_reset = 1'b0;
      i_rx_done = 1'b0;
      i_tx_done = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) run_frame(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, 0, 1'b0);
      // timeout after a lone first byte
      send_byte(8'h11);
      e = 0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (o_error) e++;
      end
      check("err_early", 8'(e), 8'd0);
      tick();
      check("timeout_err", {7'd0, o_error}, 8'd1);
      check("timeout_busy", {7'd0, o_busy}, 8'd0);
      tick();
      check("err_pulse_end", {7'd0, o_error}, 8'd0);
      run_frame(8'h02, 8'h02, 8'h20, 8'h04, 0, 1'b0);
      // byte arriving on the expiry cycle is accepted
      send_byte(8'h09);
      idle(15);
      send_byte(8'h04);
      check("edge_no_err1", {7'd0, o_error}, 8'd0);
      idle(15);
      send_byte(8'h20);
      check("edge_no_err2", {7'd0, o_error}, 8'd0);
      finish_frame(8'h0D, 1'b0);
      // extra rx byte in WAIT_TX dropped
      run_frame(8'h06, 8'h03, 8'h22, 8'h03, 1, 1'b1);
      run_frame(8'h01, 8'h01, 8'h24, 8'h01, 0, 1'b0);
      // reset after 2nd byte
      send_byte(8'h33);
      send_byte(8'h44);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      e = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (o_tx_start || o_busy) e++;
      end
      check("rst_frame_quiet", 8'(e), 8'd0);
      run_frame(8'h07, 8'h01, 8'h20, 8'h08, 0, 1'b0);
      // reset during COMPUTE
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h20);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      e = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (o_tx_start) e++;
      end
      check("rst_compute_quiet", 8'(e), 8'd0);
      check("rst_compute_data", o_tx_data, 8'h00);
      run_frame(8'h07, 8'h01, 8'h20, 8'h08, 0, 1'b0);
      // randomized frames against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
         rop = {2'($urandom), ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)]};
         run_frame(ra, rb, rop, model(ra, rb, rop), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/alu_uart_sequencer.md
ALU_UART_SEQUENCER -- requirements
Module: alu_uart_sequencer

Interface
REQ-001 The block SHALL have parameter N_BITS, default 8, as the operand, result and UART byte width.
REQ-002 The block SHALL have parameter N_BITS_OP, default 6, as the opcode width (low N_BITS_OP bits of the opcode byte).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, as the maximum clocks allowed between bytes of one frame.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_rx_data, input, N_BITS: received UART byte, valid only while i_rx_done=1.
REQ-007 The block SHALL have port i_rx_done, input, 1 bit: one-clock strobe marking a received byte.
REQ-008 The block SHALL have port i_tx_done, input, 1 bit: one-clock strobe from the UART TX marking the end of transmission.
REQ-009 The block SHALL have port o_tx_data, output, N_BITS: result byte for the UART TX.
REQ-010 The block SHALL have port o_tx_start, output, 1 bit: one-clock transmit request.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high in states COMPUTE, SEND and WAIT_TX.
REQ-012 The block SHALL have port o_error, output, 1 bit: one-clock pulse on inter-byte timeout.

Function
REQ-013 The FSM SHALL implement states WAIT_D1, WAIT_D2, WAIT_OP, COMPUTE, SEND and WAIT_TX.
REQ-014 The frame SHALL be 3 bytes in the fixed order data1, data2, opcode.
REQ-015 WAIT_D1 SHALL, on the edge with i_rx_done=1, capture data1 and go to WAIT_D2.
REQ-016 WAIT_D2 SHALL, on the edge with i_rx_done=1, capture data2 and go to WAIT_OP.
REQ-017 WAIT_OP SHALL, on the edge with i_rx_done=1, capture i_rx_data[N_BITS_OP-1:0] as the opcode and go to COMPUTE.
REQ-018 COMPUTE SHALL last exactly one clock, register the ALU output into the result register and go to SEND.
REQ-019 SEND SHALL last exactly one clock with o_tx_start=1 and o_tx_data=result, then go to WAIT_TX.
REQ-020 o_tx_start SHALL rise exactly 2 clocks after the opcode-capture edge.
REQ-021 WAIT_TX SHALL hold o_tx_data stable and, on i_tx_done=1, return to WAIT_D1.
REQ-022 Operands SHALL be treated as signed N_BITS values, and results SHALL be the ALU's N_BITS output truncated with no carry or overflow flag.
REQ-023 Supported opcodes SHALL be ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SRA 0x03, SRL 0x02 and NOR 0x27.
REQ-024 Any other opcode SHALL produce result 0x00, which SHALL still be transmitted with no error pulse.
REQ-025 A timeout counter SHALL run only in WAIT_D2 and WAIT_OP and SHALL clear on every accepted byte and on every state change.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1 without i_rx_done, the FSM SHALL discard the partial frame, pulse o_error for 1 clock and go to WAIT_D1.
REQ-027 If i_rx_done and timeout expiry occur in the same cycle, the byte SHALL be accepted and no error SHALL be raised.
REQ-028 i_rx_done SHALL be ignored in COMPUTE, SEND and WAIT_TX, with the byte dropped and no buffering.
REQ-029 i_tx_done SHALL be ignored in every state except WAIT_TX.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While i_reset=1 at a rising edge, the block SHALL set state=WAIT_D1, data1=data2=opcode=result=0 and timeout counter=0.
REQ-032 The same reset edge SHALL set o_tx_data=0x00, o_tx_start=0, o_busy=0 and o_error=0.
REQ-033 Reset SHALL take priority over i_rx_done and i_tx_done in the same cycle.
REQ-034 Reset mid-frame or mid-transmit SHALL abort without emitting o_tx_start.

Structure
REQ-035 The opcode constants, state encoding and default widths SHALL reside in the shared package alu_pkg, which is also used by alu.
REQ-036 The block SHALL instantiate exactly one sub-module, alu, fed from the captured data1, data2 and opcode registers.
REQ-037 The FSM, timeout counter and registers SHALL reside in alu_uart_sequencer.

Verification
REQ-038 The bench SHALL check: bytes 0x05, 0x03, 0x20 -> o_tx_start high exactly 2 clocks after the 3rd rx_done, with o_tx_data=0x08.
REQ-039 The bench SHALL check: bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE; then 0x40, 0x02, 0x02 (SRL) -> 0x10, with no i_tx_done lost across back-to-back frames.
REQ-040 The bench SHALL check: bytes 0x0F, 0x01, 0x3F -> o_tx_data=0x00 with o_tx_start pulsed and o_error=0.
REQ-041 The bench SHALL check, with TIMEOUT_CYCLES=16: byte 0x11 then silence -> o_error pulse at clock 16, after which 0x02, 0x02, 0x20 yields 0x04.
REQ-042 The bench SHALL check: an extra rx_done (0xAA) during WAIT_TX is ignored, and the next frame 0x01, 0x01, 0x24 yields 0x01.
REQ-043 The bench SHALL check: i_reset asserted after the 2nd byte -> no o_tx_start, and the next full frame 0x07, 0x01, 0x20 yields 0x08.
